// File: rtl/uart_pkg.sv
// Shared encodings for the UART word-transmit arbiter: FSM states, mux select values, byte width.
// Constants and types only.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } state_t;

    // Values match the external Mux_2in_1out select (A_TO_OUT / B_TO_OUT).
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational grant from the requests, last_grant updated on demand.
// Zero-cycle grant; the caller decides when a grant is taken and when to advance priority.
module rr_arbiter2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    input  logic update_src,
    output logic grant_vld,
    output logic grant_src
);

    logic last_grant;

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SEL_B;
        end else if (update) begin
            last_grant <= update_src;
        end
    end

    always_comb begin
        grant_vld = req_a | req_b;
        grant_src = SEL_A;
        if (req_a && req_b) begin
            grant_src = ~last_grant;
        end else if (req_b) begin
            grant_src = SEL_B;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two word sources onto one UART TX, latching the mux word and sending it LSB byte first.
// tx_start two edges after the grant edge; holds in SEND while tx_busy, waits for tx_done per byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              sel,
    input  logic [LENGTH-1:0] mux_q,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done
);

    localparam int NBYTES = LENGTH / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    byte_cnt;
    logic [LENGTH-1:0]   word_reg;

    logic                arb_vld;
    logic                arb_src;
    logic                grant_take;
    logic                load_word;
    logic                send_byte;
    logic                next_byte;
    logic                ack_set;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_b      (req_b),
        .update     (state == ACK),
        .update_src (sel),
        .grant_vld  (arb_vld),
        .grant_src  (arb_src)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_take = 1'b0;
        load_word  = 1'b0;
        send_byte  = 1'b0;
        next_byte  = 1'b0;
        ack_set    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    grant_take = 1'b1;
                    state_nxt  = LATCH;
                end
            end
            LATCH: begin
                load_word = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    send_byte = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt == LAST_BYTE) begin
                        ack_set   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        next_byte = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ack is registered on entry to ACK so it is high during the ACK cycle itself;
    // a requester dropping its level in that cycle is not re-granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel      <= SEL_A;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            byte_cnt <= '0;
            word_reg <= '0;
        end else begin
            tx_start <= send_byte;
            ack_a    <= ack_set && (sel == SEL_A);
            ack_b    <= ack_set && (sel == SEL_B);
            if (grant_take) begin
                sel <= arb_src;
            end
            if (load_word) begin
                word_reg <= mux_q;
                byte_cnt <= '0;
            end
            if (send_byte) begin
                tx_data <= word_reg[BYTE_W*byte_cnt +: BYTE_W];
            end
            if (next_byte) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: mux and UART models, byte/ack scoreboard queues, directed scenarios.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int BYTE_TIME = 10;
    localparam int BUDGET    = 2000;

    logic        clk;
    logic        rst;
    logic        req_a, req_b;
    logic        ack_a, ack_b;
    logic        sel;
    logic [31:0] mux_q;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy, tx_done;

    logic [31:0] word_a, word_b;
    logic        uart_busy, uart_done, hold_busy, stray_done;
    int          uart_cnt;

    typedef struct {
        logic [7:0] dat;
        logic       src;
    } exp_t;

    exp_t exp_bytes[$];
    logic exp_acks[$];

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int bytes_in_word = 0;

    assign mux_q   = (sel == SEL_B) ? word_b : word_a;
    assign tx_busy = uart_busy | hold_busy;
    assign tx_done = uart_done | stray_done;

    uart_tx_arbiter #(.LENGTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .sel      (sel),
        .mux_q    (mux_q),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic src, input logic [31:0] w);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.dat = w[8*i +: 8];
            e.src = src;
            exp_bytes.push_back(e);
        end
        exp_acks.push_back(src);
    endtask

    task automatic wait_acks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (ack_a | ack_b) seen++;
        end
        if (seen < n) chk("ack_timeout", seen, n);
    endtask

    task automatic wait_starts(input int target);
        int cyc = 0;
        while (n_start < target && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (n_start < target) chk("start_timeout", n_start, target);
    endtask

    task automatic count_to_start(output int cnt);
        cnt = 0;
        while (cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (tx_start) break;
        end
    endtask

    // UART model and scoreboard consumer, sampled just after each rising edge.
    initial begin
        uart_busy = 1'b0;
        uart_done = 1'b0;
        uart_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                bytes_in_word = 0;
            end else begin
                if (tx_start) begin
                    chk("start_while_busy", tx_busy, 1'b0);
                    if (exp_bytes.size() == 0) begin
                        chk("unexpected_byte", tx_data, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_bytes.pop_front();
                        chk("tx_data", tx_data, e.dat);
                        chk("sel_during_byte", sel, e.src);
                    end
                    n_start++;
                    bytes_in_word++;
                end
                if (ack_a | ack_b) begin
                    chk("ack_both", ack_a & ack_b, 1'b0);
                    if (exp_acks.size() == 0) begin
                        chk("unexpected_ack", {ack_b, ack_a}, 0);
                    end else begin
                        chk("ack_src", ack_b, exp_acks.pop_front());
                    end
                    chk("bytes_per_word", bytes_in_word, 4);
                    bytes_in_word = 0;
                end
            end
            uart_done = 1'b0;
            if (uart_busy) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    uart_busy = 1'b0;
                    uart_done = 1'b1;
                end
            end else if (tx_start && rst) begin
                uart_busy = 1'b1;
                uart_cnt  = BYTE_TIME;
            end
        end
    end

    initial begin
        int   cnt;
        int   starts0;
        exp_t e;
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        hold_busy = 1'b0; stray_done = 1'b0;
        word_a = 32'h0; word_b = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_state", dut.state, IDLE);
        chk("rst_sel", sel, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_ack", {ack_b, ack_a}, 2'b00);
        rst = 1'b1;

        // Single A request, first-transaction latency
        word_a = 32'hDEADBEEF;
        push_word(SEL_A, word_a);
        @(negedge clk);
        req_a = 1'b1;
        count_to_start(cnt);
        chk("first_latency", cnt, 3);
        wait_acks(1);
        req_a = 1'b0;

        // Simultaneous requests after reset: A first, then B
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        word_a = 32'hCAFEF00D;
        word_b = 32'h12345678;
        push_word(SEL_A, word_a);
        push_word(SEL_B, word_b);
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b1;
        wait_acks(1);
        req_a = 1'b0;
        count_to_start(cnt);
        chk("b_gap_after_ack", cnt, 4);
        wait_acks(1);
        req_b = 1'b0;

        // Persistent requests alternate A, B, A, B
        word_a = 32'h01020304;
        word_b = 32'hA0B0C0D0;
        push_word(SEL_A, word_a);
        push_word(SEL_B, word_b);
        push_word(SEL_A, word_a);
        push_word(SEL_B, word_b);
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b1;
        wait_acks(4);
        req_a = 1'b0; req_b = 1'b0;

        // Back-pressure held for 50 cycles in SEND
        @(negedge clk);
        hold_busy = 1'b1;
        word_a = 32'hA5A55A5A;
        push_word(SEL_A, word_a);
        starts0 = n_start;
        req_a = 1'b1;
        repeat (50) @(negedge clk);
        chk("bp_state", dut.state, SEND);
        chk("bp_no_start", n_start, starts0);
        hold_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_start", tx_start, 1'b1);
        wait_acks(1);
        req_a = 1'b0;

        // Stray tx_done in IDLE, then B drops its request after byte 1
        repeat (3) @(negedge clk);
        starts0 = n_start;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        chk("stray_state", dut.state, IDLE);
        chk("stray_no_start", n_start, starts0);
        word_b = 32'h0BADCAFE;
        push_word(SEL_B, word_b);
        req_b = 1'b1;
        wait_starts(starts0 + 2);
        req_b = 1'b0;
        wait_acks(1);

        // Reset during the second byte of a B word
        repeat (2) @(negedge clk);
        word_b = 32'h87654321;
        e.src = SEL_B;
        e.dat = 8'h21; exp_bytes.push_back(e);
        e.dat = 8'h43; exp_bytes.push_back(e);
        starts0 = n_start;
        req_b = 1'b1;
        wait_starts(starts0 + 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_b = 1'b0;
        #1;
        chk("arst_state", dut.state, IDLE);
        chk("arst_sel", sel, 1'b0);
        chk("arst_tx_data", tx_data, 8'h00);
        chk("arst_tx_start", tx_start, 1'b0);
        chk("arst_ack", {ack_b, ack_a}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        word_a = 32'h55AA33CC;
        push_word(SEL_A, word_a);
        @(negedge clk);
        req_a = 1'b1;
        wait_acks(1);
        req_a = 1'b0;

        repeat (20) @(negedge clk);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("acks_left", exp_acks.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the UART transmitter between two 32-bit word sources, A (CPU result) and B (status/debug).
- Arbitrates round-robin between the sources and drives the select of the external 2:1 word mux (Mux_2in_1out).
- Latches the mux output, then serializes the latched word LSB-byte-first into the UART TX byte interface with a start/done handshake.
- Acknowledges the requester when its last byte has gone out.

Parameters:
- LENGTH, 32, word width of the mux inputs/output; must be a multiple of 8.
- NBYTES, LENGTH/8, bytes per word (derived localparam, not overridable).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous, active-low reset; 0 resets all state immediately.
- req_a, input, 1, source A requests transmission; level, held until ack_a.
- req_b, input, 1, source B requests transmission; level, held until ack_b.
- ack_a, output, 1, one-cycle pulse: A's word fully transmitted.
- ack_b, output, 1, one-cycle pulse: B's word fully transmitted.
- sel, output, 1, mux select (0 = A, 1 = B); registered.
- mux_q, input, LENGTH, word from mux output Q.
- tx_data, output, 8, byte to UART TX; registered.
- tx_start, output, 1, one-cycle pulse launching tx_data.
- tx_busy, input, 1, UART TX currently shifting.
- tx_done, input, 1, one-cycle pulse: UART finished current byte.

Behaviour:
Reset (rst=0, asynchronous) forces:
- state=IDLE, sel=0, tx_data=0x00, tx_start=0, ack_a=0, ack_b=0.
- byte_cnt=0, word_reg=0, last_grant=B (so A wins the first tie).

FSM states: IDLE, LATCH, SEND, WAIT, ACK.

IDLE:
- Nothing requesting: stay in IDLE.
- Only req_a: grant A, sel<=0.
- Only req_b: grant B, sel<=1.
- Both: grant the source that is not last_grant.
- On any grant: go to LATCH.
- sel holds its last value while idle.

LATCH:
- word_reg<=mux_q. sel has been stable for a full cycle, so the mux output is settled.
- byte_cnt<=0; go to SEND.

SEND:
- If tx_busy=0: tx_data<=word_reg[8*byte_cnt +: 8], tx_start<=1 for exactly one cycle, go to WAIT.
- If tx_busy=1: hold in SEND with tx_start=0.

WAIT:
- On tx_done: if byte_cnt==NBYTES-1, go to ACK; else byte_cnt<=byte_cnt+1 and go to SEND.
- No timeout.

ACK:
- Pulse ack of the granted source for one cycle, last_grant<=granted source, go to IDLE.

Latency and throughput:
- Request sampled in IDLE at edge N → LATCH at N+1 → tx_start high in the cycle after edge N+2.
- Minimum time between bytes: 2 cycles plus the UART byte time.

Boundary conditions:
- Request deasserted mid-transfer: ignored; the word completes and the ack still pulses.
- New request from the other source during a transfer: serviced after ACK, no loss.
- Requester still asserting in the cycle after its ack: treated as a new request. Round-robin still grants the other source first if both are requesting.
- tx_done outside WAIT: ignored.
- tx_start never asserts while tx_busy=1.
- sel never changes outside IDLE, so the mux output is stable for the whole transfer.
- ack_a and ack_b are never high together.
- Reset mid-transfer: abort immediately with outputs at reset values; no partial ack.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=3'd0, LATCH=3'd1, SEND=3'd2, WAIT=3'd3, ACK=3'd4);
  - SEL_A=1'b0 and SEL_B=1'b1, matching the mux's A_TO_OUT/B_TO_OUT;
  - BYTE_W=8.
- One sub-module is natural: rr_arbiter2 (2-way round-robin grant with last_grant register), instantiated once.
- Byte slicing stays inline.

Test Plan:
- Reset mid-transfer: assert rst=0 during byte 2 → all outputs and state at reset values asynchronously. After release, a fresh req_a sends from byte 0.
- Single A request:
  - Stimulus: req_a=1, mux model returns 0xDEADBEEF for sel=0; UART model busy 10 cycles per byte.
  - Response: sel=0; tx_data sequence EF, BE, AD, DE with one tx_start each; ack_a single pulse after the 4th tx_done; ack_b never asserts.
- Simultaneous requests after reset:
  - Stimulus: req_a=req_b=1 (B word 0x12345678).
  - Response: A is served first, then sel=1 and bytes 78, 56, 34, 12, then ack_b. No gap beyond IDLE→LATCH.
- Fairness under persistent requests: hold req_a=req_b=1 for 4 words → grant order A, B, A, B.
- Back-pressure: hold tx_busy=1 for 50 cycles while in SEND → tx_start stays 0 and the FSM stays in SEND. tx_start pulses once, the cycle after tx_busy falls.
- Stray handshake and request drop:
  - Stimulus: tx_done pulse while IDLE; req_b dropped after byte 1.
  - Response: no state change on the stray tx_done; all 4 bytes of B still sent and ack_b pulses.
